mem_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM (1-cycle registered read, write on cs&we) between
//  two requesters: port V (video fetch: font 0xE000, screen 0xF000; read-only, high priority)
//  and port C (CPU; read/write). Sits between the CPU/video blocks and the Memory instance.

---
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: video (read-only, high
// priority) and CPU (read/write), with a wait counter that bounds CPU starvation.
module mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_v_req,
  input  logic [ADDR_W-1:0] i_v_addr,
  output logic              o_v_ack,
  output logic              o_v_valid,
  output logic [DATA_W-1:0] o_v_dat,
  input  logic              i_c_req,
  input  logic              i_c_we,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [DATA_W-1:0] i_c_dat,
  output logic              o_c_ack,
  output logic              o_c_valid,
  output logic [DATA_W-1:0] o_c_dat,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_dat,
  output logic              o_mem_cs,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_dat
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_V, S_C} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          v_pend, c_pend;
  logic          v_elig, c_elig;

  // state holds the grant being issued this cycle, so it doubles as the ack mask
  always_comb begin
    state_nxt = S_IDLE;
    wait_nxt  = wait_cnt;
    v_elig    = i_v_req && (state != S_V);
    c_elig    = i_c_req && (state != S_C);
    if (v_elig && c_elig) begin
      if (wait_cnt == WAIT_LIM) begin
        state_nxt = S_C;
        wait_nxt  = '0;
      end else begin
        state_nxt = S_V;
        wait_nxt  = wait_cnt + 1'b1;
      end
    end else if (v_elig) begin
      state_nxt = S_V;
    end else if (c_elig) begin
      state_nxt = S_C;
      wait_nxt  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      v_pend     <= 1'b0;
      c_pend     <= 1'b0;
      o_mem_addr <= '0;
      o_mem_dat  <= '0;
      o_mem_we   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      v_pend   <= (state == S_V);
      c_pend   <= (state == S_C) && !o_mem_we;
      case (state_nxt)
        S_V: begin
          o_mem_addr <= i_v_addr;
          o_mem_dat  <= '0;
          o_mem_we   <= 1'b0;
        end
        S_C: begin
          o_mem_addr <= i_c_addr;
          o_mem_dat  <= i_c_dat;
          o_mem_we   <= i_c_we;
        end
        default: o_mem_we <= 1'b0;
      endcase
    end
  end

  // valid is gated by reset so a read landing in the reset cycle is dropped
  always_comb begin
    o_v_ack   = (state == S_V);
    o_c_ack   = (state == S_C);
    o_mem_cs  = (state != S_IDLE);
    o_v_valid = v_pend && !i_reset;
    o_c_valid = c_pend && !i_reset;
    o_v_dat   = i_mem_dat;
    o_c_dat   = i_mem_dat;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM (registered read).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        v_req, v_ack, v_valid;
  logic [15:0] v_addr;
  logic [7:0]  v_dat;
  logic        c_req, c_we, c_ack, c_valid;
  logic [15:0] c_addr;
  logic [7:0]  c_wdat, c_dat;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdat, mem_rdat;
  logic        mem_cs, mem_we;

  logic [7:0]  ram [0:65535];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(4)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_v_req(v_req), .i_v_addr(v_addr), .o_v_ack(v_ack), .o_v_valid(v_valid), .o_v_dat(v_dat),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_dat(c_wdat),
    .o_c_ack(c_ack), .o_c_valid(c_valid), .o_c_dat(c_dat),
    .o_mem_addr(mem_addr), .o_mem_dat(mem_wdat), .o_mem_cs(mem_cs), .o_mem_we(mem_we),
    .i_mem_dat(mem_rdat)
  );

  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) ram[mem_addr] <= mem_wdat;
      mem_rdat <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    for (int unsigned i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'hF000] = 8'h41;
    mem_rdat = 8'h00;
    reset = 1'b1;
    v_req = 1'b1; v_addr = 16'hF000;
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h1234; c_wdat = 8'h00;

    // 1: reset with both requests held
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_v_ack", v_ack, 0);
      chk("rst_c_ack", c_ack, 0);
      chk("rst_v_valid", v_valid, 0);
      chk("rst_c_valid", c_valid, 0);
      chk("rst_cs", mem_cs, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_dat", mem_wdat, 0);
    end
    reset = 1'b0;
    step();
    chk("post_rst_v_ack", v_ack, 1);
    chk("post_rst_c_ack", c_ack, 0);
    v_req = 1'b0; c_req = 1'b0;
    step();
    step();

    // 2: CPU write then read-back
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'h1234; c_wdat = 8'hA5;
    step();
    chk("wr_ack", c_ack, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 16'h1234);
    chk("wr_dat", mem_wdat, 8'hA5);
    c_we = 1'b0; c_wdat = 8'h00;
    step();
    chk("wr_mask_ack", c_ack, 0);
    chk("wr_no_valid", c_valid, 0);
    step();
    chk("rd_ack", c_ack, 1);
    chk("rd_we", mem_we, 0);
    c_req = 1'b0;
    step();
    chk("rd_valid", c_valid, 1);
    chk("rd_dat", c_dat, 8'hA5);

    // 3: video read alone
    v_req = 1'b1; v_addr = 16'hF000;
    step();
    chk("v_ack", v_ack, 1);
    chk("v_cs", mem_cs, 1);
    chk("v_we", mem_we, 0);
    chk("v_addr", mem_addr, 16'hF000);
    v_req = 1'b0;
    step();
    chk("v_valid", v_valid, 1);
    chk("v_dat", v_dat, 8'h41);
    chk("v_ack_drop", v_ack, 0);
    step();

    // 4: both held continuously -> V,C,V,C...
    v_req = 1'b1; c_req = 1'b1; c_we = 1'b0; c_addr = 16'h1234;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("alt_v_ack", v_ack, (i % 2 == 0) ? 1 : 0);
      chk("alt_c_ack", c_ack, (i % 2 == 1) ? 1 : 0);
      chk("alt_addr", mem_addr, (i % 2 == 0) ? 16'hF000 : 16'h1234);
      if (i > 0) begin
        chk("alt_v_valid", v_valid, (i % 2 == 1) ? 1 : 0);
        chk("alt_c_valid", c_valid, (i % 2 == 0) ? 1 : 0);
        if (i % 2 == 1) chk("alt_v_dat", v_dat, 8'h41);
        else            chk("alt_c_dat", c_dat, 8'hA5);
      end
    end
    v_req = 1'b0; c_req = 1'b0;
    step();
    step();

    // 5: isolated contests; the fifth goes to C, the sixth back to V
    for (int i = 0; i < 6; i++) begin
      v_req = 1'b1; c_req = 1'b1;
      step();
      chk("starve_v_ack", v_ack, (i == 4) ? 0 : 1);
      chk("starve_c_ack", c_ack, (i == 4) ? 1 : 0);
      v_req = 1'b0; c_req = 1'b0;
      step();
    end
    step();

    // 6: reset in the cycle after a CPU read ack
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h1234;
    step();
    chk("rr_ack", c_ack, 1);
    c_req = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("rr_no_valid", c_valid, 0);
    step();
    chk("rr_cs", mem_cs, 0);
    chk("rr_valid2", c_valid, 0);
    reset = 1'b0;
    step();
    chk("rr_idle_cs", mem_cs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
